// File: rtl/snax_gemmx_launch_sequencer_pkg.sv
// Shared types and constants for the GEMMX launch sequencer.
// Holds the CSR geometry, the CSR word indices, the sequencer state enum,
// the captured launch configuration struct and a helper that unpacks the
// flat RW CSR vector into that struct.
package snax_gemmx_seq_pkg;

    localparam int RegRWCount   = 10;
    localparam int RegROCount   = 3;
    localparam int RegDataWidth = 32;
    localparam int DimWidth     = 16;

    // RW CSR word indices
    localparam int K_IDX      = 0;
    localparam int N_IDX      = 1;
    localparam int M_IDX      = 2;
    localparam int SUB_IDX    = 3;
    localparam int SIMD_IDX   = 4;
    localparam int BYPASS_IDX = 8;

    // RO CSR word indices
    localparam int PERF_IDX   = 0;
    localparam int STATUS_IDX = 1;
    localparam int CNT_IDX    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [RegDataWidth-1:0]   sub;
        logic [RegDataWidth-1:0]   m;
        logic [RegDataWidth-1:0]   n;
        logic [RegDataWidth-1:0]   k;
        logic [4*RegDataWidth-1:0] simd;
        logic                      bypass;
    } seq_cfg_t;

    function automatic seq_cfg_t unpack_cfg(input logic [RegRWCount*RegDataWidth-1:0] words);
        seq_cfg_t cfg;
        cfg.k      = words[K_IDX*RegDataWidth +: RegDataWidth];
        cfg.n      = words[N_IDX*RegDataWidth +: RegDataWidth];
        cfg.m      = words[M_IDX*RegDataWidth +: RegDataWidth];
        cfg.sub    = words[SUB_IDX*RegDataWidth +: RegDataWidth];
        cfg.simd   = words[SIMD_IDX*RegDataWidth +: 4*RegDataWidth];
        cfg.bypass = words[BYPASS_IDX*RegDataWidth];
        return cfg;
    endfunction

endpackage

// File: rtl/snax_gemmx_launch_sequencer_if.sv
// Bus bundle between the CSR manager / GEMM+SIMD block and the sequencer.
// slave  : the sequencer side (takes config, drives ctrl channels, snoops beats)
// master : the environment side (writes config, accepts ctrl, produces beats)
interface snax_gemmx_launch_sequencer_if;
    import snax_gemmx_seq_pkg::*;

    logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i;
    logic                               csr_reg_set_valid_i;
    logic                               csr_reg_set_ready_o;
    logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o;
    logic                               gemm_ctrl_valid_o;
    logic                               gemm_ctrl_ready_i;
    logic [4*RegDataWidth-1:0]          gemm_ctrl_bits_o;
    logic                               simd_ctrl_valid_o;
    logic                               simd_ctrl_ready_i;
    logic [4*RegDataWidth-1:0]          simd_ctrl_bits_o;
    logic                               bypass_simd_o;
    logic                               d32_valid_i;
    logic                               d32_ready_i;
    logic                               d8_valid_i;
    logic                               d8_ready_i;

    modport slave (
        input  csr_reg_set_i, csr_reg_set_valid_i,
        input  gemm_ctrl_ready_i, simd_ctrl_ready_i,
        input  d32_valid_i, d32_ready_i, d8_valid_i, d8_ready_i,
        output csr_reg_set_ready_o, csr_reg_ro_set_o,
        output gemm_ctrl_valid_o, gemm_ctrl_bits_o,
        output simd_ctrl_valid_o, simd_ctrl_bits_o, bypass_simd_o
    );

    modport master (
        output csr_reg_set_i, csr_reg_set_valid_i,
        output gemm_ctrl_ready_i, simd_ctrl_ready_i,
        output d32_valid_i, d32_ready_i, d8_valid_i, d8_ready_i,
        input  csr_reg_set_ready_o, csr_reg_ro_set_o,
        input  gemm_ctrl_valid_o, gemm_ctrl_bits_o,
        input  simd_ctrl_valid_o, simd_ctrl_bits_o, bypass_simd_o
    );

endinterface

// File: rtl/snax_gemmx_launch_sequencer_handshake.sv
// Per-channel sticky valid/done latch for one control channel.
// Ports: clk_i/rst_ni clock and async active-low reset; clear_i restarts the
// channel for a new launch; enable_i allows valid to be raised; ready_i is the
// consumer ready; valid_o is the registered channel valid; done_o is sticky
// once the channel has handshaked, until the next clear_i.
module snax_gemmx_seq_handshake (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    input  logic ready_i,
    output logic valid_o,
    output logic done_o
);

    logic valid_q, valid_d;
    logic done_q, done_d;

    // Valid is raised only while enabled and not yet done, so it can never be
    // re-raised after the handshake of the current launch.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (clear_i) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
        end else if (enable_i && !done_q && !valid_q) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;

endmodule

// File: rtl/snax_gemmx_launch_sequencer.sv
// Launch sequencer between the CSR manager and the GEMM+SIMD block.
// Captures one configuration into a shadow slot, issues it on the GEMM and
// SIMD control channels, then waits for M*N output beats on the active stream
// (d32 when SIMD is bypassed, d8 otherwise).
// Ports: clk_i clock; rst_ni async active-low reset; bus (slave modport) with
// the config handshake, RO CSRs {launch count, status, perf cycles}, both
// control channels, bypass select and the two snooped output streams.
module snax_gemmx_launch_sequencer
    import snax_gemmx_seq_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    snax_gemmx_launch_sequencer_if.slave  bus
);

    localparam logic [RegDataWidth-1:0] PerfMax = '1;

    seq_state_e              state_q, state_d;
    seq_cfg_t                shadow_q, shadow_d, active_q, active_d;
    logic                    shadow_full_q, shadow_full_d;
    logic [2*DimWidth-1:0]   target_q, target_d, beat_cnt_q, beat_cnt_d;
    logic [RegDataWidth-1:0] perf_q, perf_d, launch_cnt_q, launch_cnt_d;
    logic                    launch, gemm_done, simd_done, beat, busy;
    logic [DimWidth-1:0]     next_m, next_n;
    logic [RegDataWidth-1:0] status;
    logic                    unused_csr_bits;

    assign busy   = (state_q != IDLE);
    assign beat   = active_q.bypass ? (bus.d32_valid_i && bus.d32_ready_i)
                                    : (bus.d8_valid_i && bus.d8_ready_i);
    assign next_m = shadow_q.m[DimWidth-1:0];
    assign next_n = shadow_q.n[DimWidth-1:0];

    // Only bit 0 of the bypass word is meaningful; the reserved word is ignored.
    assign unused_csr_bits = ^bus.csr_reg_set_i[RegRWCount*RegDataWidth-1:BYPASS_IDX*RegDataWidth+1];

    snax_gemmx_seq_handshake u_gemm_hs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (launch),
        .enable_i (state_q == ISSUE),
        .ready_i  (bus.gemm_ctrl_ready_i),
        .valid_o  (bus.gemm_ctrl_valid_o),
        .done_o   (gemm_done)
    );

    snax_gemmx_seq_handshake u_simd_hs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (launch),
        .enable_i (state_q == ISSUE),
        .ready_i  (bus.simd_ctrl_ready_i),
        .valid_o  (bus.simd_ctrl_valid_o),
        .done_o   (simd_done)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        target_d      = target_q;
        beat_cnt_d    = beat_cnt_q;
        perf_d        = perf_q;
        launch_cnt_d  = launch_cnt_q;
        launch        = 1'b0;

        if (bus.csr_reg_set_valid_i && !shadow_full_q) begin
            shadow_d      = unpack_cfg(bus.csr_reg_set_i);
            shadow_full_d = 1'b1;
        end

        // Beats are counted in ISSUE as well as RUN and saturate at the target.
        if (busy) begin
            if (perf_q != PerfMax) perf_d = perf_q + 1;
            if (beat && (beat_cnt_q != target_q)) beat_cnt_d = beat_cnt_q + 1;
        end

        case (state_q)
            IDLE: begin
                // Pick up the pending launch; a zero-sized one completes at once.
                if (shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_full_d = 1'b0;
                    perf_d        = '0;
                    if ((next_m == '0) || (next_n == '0)) begin
                        launch_cnt_d = launch_cnt_q + 1;
                    end else begin
                        target_d   = {{DimWidth{1'b0}}, next_m} * {{DimWidth{1'b0}}, next_n};
                        beat_cnt_d = '0;
                        launch     = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (gemm_done && simd_done) state_d = RUN;
            end
            RUN: begin
                if (beat_cnt_d == target_q) begin
                    launch_cnt_d = launch_cnt_q + 1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
            target_q      <= '0;
            beat_cnt_q    <= '0;
            perf_q        <= '0;
            launch_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            target_q      <= target_d;
            beat_cnt_q    <= beat_cnt_d;
            perf_q        <= perf_d;
            launch_cnt_q  <= launch_cnt_d;
        end
    end

    assign status                  = {{(RegDataWidth-2){1'b0}}, shadow_full_q, busy};
    assign bus.csr_reg_set_ready_o = !shadow_full_q;
    assign bus.csr_reg_ro_set_o    = {launch_cnt_q, status, perf_q};
    assign bus.gemm_ctrl_bits_o    = {active_q.sub, active_q.m, active_q.n, active_q.k};
    assign bus.simd_ctrl_bits_o    = active_q.simd;
    assign bus.bypass_simd_o       = active_q.bypass;

endmodule

// File: tb/tb_snax_gemmx_launch_sequencer.sv
// Self-checking bench for snax_gemmx_launch_sequencer: a per-cycle vector
// table for the basic launch plus directed sequences for skewed handshakes,
// bypass routing, back-to-back launches, zero dimensions and reset mid-run.
module tb_snax_gemmx_launch_sequencer;
    import snax_gemmx_seq_pkg::*;

    typedef logic [RegRWCount*RegDataWidth-1:0] cfg_vec_t;

    typedef struct {
        logic        setValid;
        logic        gemmReady;
        logic        simdReady;
        logic        d8Beat;
        logic        d32Beat;
        logic        expGemmValid;
        logic        expSimdValid;
        logic [1:0]  expStatus;
        logic [31:0] expPerf;
        logic [31:0] expCount;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[12];

    snax_gemmx_launch_sequencer_if bus();

    snax_gemmx_launch_sequencer dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the design wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic cfg_vec_t mkCfg(input logic [31:0] m, input logic [31:0] n, input logic bypass);
        cfg_vec_t c;
        c = '0;
        c[K_IDX*32 +: 32]   = 32'd7;
        c[N_IDX*32 +: 32]   = n;
        c[M_IDX*32 +: 32]   = m;
        c[SUB_IDX*32 +: 32] = 32'd3;
        for (int i = 0; i < 4; i++) c[(SIMD_IDX+i)*32 +: 32] = 32'(32'hA0 + i);
        c[BYPASS_IDX*32 +: 32] = {31'h7fff_fffe, bypass};
        c[9*32 +: 32] = 32'hDEAD_BEEF;
        return c;
    endfunction

    function automatic logic [1:0] getStatus();
        return bus.csr_reg_ro_set_o[STATUS_IDX*32 +: 2];
    endfunction

    function automatic logic [31:0] getPerf();
        return bus.csr_reg_ro_set_o[PERF_IDX*32 +: 32];
    endfunction

    function automatic logic [31:0] getCount();
        return bus.csr_reg_ro_set_o[CNT_IDX*32 +: 32];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the next edge.
    task automatic applyStimulus(input logic sv, input logic gr, input logic sr, input logic d8, input logic d32);
        bus.csr_reg_set_valid_i = sv;
        bus.gemm_ctrl_ready_i   = gr;
        bus.simd_ctrl_ready_i   = sr;
        bus.d8_valid_i          = d8;
        bus.d8_ready_i          = d8;
        bus.d32_valid_i         = d32;
        bus.d32_ready_i         = d32;
        @(posedge clk);
        #1;
    endtask

    // Write a config and step it through ISSUE into RUN with readies high.
    task automatic launchToRun(input string tag, input cfg_vec_t c);
        bus.csr_reg_set_i = c;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, " valids up"}, {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b11);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput({tag, " valids down"}, {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, " busy in run"}, getStatus(), 2'b01);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " ready"}, bus.csr_reg_set_ready_o, 1'b1);
        checkOutput({tag, " ro"}, bus.csr_reg_ro_set_o, '0);
        checkOutput({tag, " valids"}, {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b00);
        checkOutput({tag, " gemm bits"}, bus.gemm_ctrl_bits_o, '0);
        checkOutput({tag, " simd bits"}, bus.simd_ctrl_bits_o, '0);
        checkOutput({tag, " bypass"}, bus.bypass_simd_o, 1'b0);
    endtask

    // Main directed sequence.
    initial begin
        int cycles;
        bus.csr_reg_set_i = '0;
        bus.csr_reg_set_valid_i = 1'b0;
        bus.gemm_ctrl_ready_i = 1'b0;
        bus.simd_ctrl_ready_i = 1'b0;
        bus.d8_valid_i = 1'b0;
        bus.d8_ready_i = 1'b0;
        bus.d32_valid_i = 1'b0;
        bus.d32_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_ni = 1'b1;

        // Basic launch M=2 N=3 on the d8 stream, one row per cycle.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'd0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 32'd1, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'd2, 32'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'd3, 32'd0};
        for (int i = 5; i < 10; i++)
            vecs[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'(i - 1), 32'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd9, 32'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd9, 32'd1};

        bus.csr_reg_set_i = mkCfg(32'd2, 32'd3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].setValid, vecs[i].gemmReady, vecs[i].simdReady, vecs[i].d8Beat, vecs[i].d32Beat);
            checkOutput($sformatf("basic[%0d] valids", i), {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o},
                        {vecs[i].expGemmValid, vecs[i].expSimdValid});
            checkOutput($sformatf("basic[%0d] status", i), getStatus(), vecs[i].expStatus);
            checkOutput($sformatf("basic[%0d] perf", i), getPerf(), vecs[i].expPerf);
            checkOutput($sformatf("basic[%0d] count", i), getCount(), vecs[i].expCount);
            if (vecs[i].expGemmValid) begin
                checkOutput("basic gemm bits", bus.gemm_ctrl_bits_o, {32'd3, 32'd2, 32'd3, 32'd7});
                checkOutput("basic simd bits", bus.simd_ctrl_bits_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
                checkOutput("basic bypass", bus.bypass_simd_o, 1'b0);
            end
        end

        // Skewed handshakes: gemm ready one cycle after valid, simd five cycles after.
        bus.csr_reg_set_i = mkCfg(32'd1, 32'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("skew valids up", {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("skew +0 valids held", {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b11);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("skew +1 gemm drop", {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("skew +2 simd held", {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b01);
        for (int i = 3; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("skew +%0d simd held", i), {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b01);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("skew +5 simd drop", {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b00);
        checkOutput("skew +5 busy", getStatus(), 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("skew +6 busy", getStatus(), 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("skew done status", getStatus(), 2'b00);
        checkOutput("skew count", getCount(), 32'd2);
        checkOutput("skew perf", getPerf(), 32'd9);

        // Bypass routing: d8 beats ignored, completion on the fourth d32 beat.
        launchToRun("bypass", mkCfg(32'd1, 32'd4, 1'b1));
        checkOutput("bypass select", bus.bypass_simd_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("bypass d8 beat %0d busy", i), getStatus(), 2'b01);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("bypass d32 beat %0d status", i), getStatus(), (i == 3) ? 2'b00 : 2'b01);
        end
        checkOutput("bypass count", getCount(), 32'd3);
        checkOutput("bypass select held", bus.bypass_simd_o, 1'b1);

        // Back-to-back: A runs, B waits in the shadow, C stalls until A completes.
        launchToRun("b2b A", mkCfg(32'd1, 32'd2, 1'b0));
        bus.csr_reg_set_i = mkCfg(32'd1, 32'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("b2b B accepted ready", bus.csr_reg_set_ready_o, 1'b0);
        checkOutput("b2b B accepted status", getStatus(), 2'b11);
        bus.csr_reg_set_i = mkCfg(32'd1, 32'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b C stalled ready", bus.csr_reg_set_ready_o, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("b2b A done status", getStatus(), 2'b10);
        checkOutput("b2b A done count", getCount(), 32'd4);
        checkOutput("b2b A done ready", bus.csr_reg_set_ready_o, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b B issued status", getStatus(), 2'b01);
        checkOutput("b2b B issued ready", bus.csr_reg_set_ready_o, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b C accepted status", getStatus(), 2'b11);
        cycles = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            cycles++;
        end while ((getStatus() != 2'b00) && (cycles < 40));
        checkOutput("b2b drain status", getStatus(), 2'b00);
        checkOutput("b2b drain count", getCount(), 32'd6);

        // Zero dimensions: M=0 and then N=0 complete without any ctrl activity.
        bus.csr_reg_set_i = mkCfg(32'd0, 32'd5, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("zeroM queued status", getStatus(), 2'b10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("zeroM[%0d] status", i), getStatus(), 2'b00);
            checkOutput($sformatf("zeroM[%0d] valids", i), {bus.gemm_ctrl_valid_o, bus.simd_ctrl_valid_o}, 2'b00);
        end
        checkOutput("zeroM count", getCount(), 32'd7);
        checkOutput("zeroM perf", getPerf(), 32'd0);
        bus.csr_reg_set_i = mkCfg(32'd3, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("zeroN status", getStatus(), 2'b00);
        checkOutput("zeroN count", getCount(), 32'd8);

        // Reset in the middle of RUN, then a fresh 1x1 launch.
        launchToRun("rstrun", mkCfg(32'd2, 32'd3, 1'b0));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rstrun busy before reset", getStatus(), 2'b01);
        rst_ni = 1'b0;
        #2;
        checkResetState("midreset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        launchToRun("after reset", mkCfg(32'd1, 32'd1, 1'b0));
        checkOutput("after reset count before beat", getCount(), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("after reset status", getStatus(), 2'b00);
        checkOutput("after reset count", getCount(), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
